// File: rtl/banco_registradores.sv
`timescale 1ns/1ps
// Purpose: register file with two combinational read ports, one write port, reg 0 tied to zero and a clear sweep.
// Latency: reads and write-through bypass are zero-latency; a write lands on the next Clock edge.
// Backpressure: none; while Ocupado is high, writes and new Limpar requests are silently dropped.
//
// Ports:
//   Clock, Reset                 rising-edge clock, asynchronous active-low reset
//   EndLeitura0/1, Leitura0/1    read addresses and read data
//   EndEscrita, DadoEscrita,
//   HabEscrita                   write address, data and enable
//   Limpar, Ocupado              clear request and sweep-in-progress flag
module banco_registradores #(
  parameter int LARGURA = 4,
  parameter int NREG    = 8,
  parameter int ENDW    = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [ENDW-1:0]    EndLeitura0,
  input  logic [ENDW-1:0]    EndLeitura1,
  input  logic [ENDW-1:0]    EndEscrita,
  input  logic [LARGURA-1:0] DadoEscrita,
  input  logic               HabEscrita,
  input  logic               Limpar,
  output logic [LARGURA-1:0] Leitura0,
  output logic [LARGURA-1:0] Leitura1,
  output logic               Ocupado
);

  typedef enum logic {OCIOSO = 1'b0, LIMPANDO = 1'b1} estado_t;

  localparam logic [ENDW-1:0] IDX_PRIMEIRO = ENDW'(1);
  localparam logic [ENDW-1:0] IDX_ULTIMO   = ENDW'(NREG - 1);

  estado_t            estado, prox_estado;
  logic [ENDW-1:0]    indice, prox_indice;
  logic [LARGURA-1:0] regs [NREG];

  // Write-through is visible whenever an idle-state write to a non-zero address is presented.
  logic bypass;
  // The actual store additionally loses to a same-cycle Limpar.
  logic escreve;

  assign bypass  = HabEscrita && (EndEscrita != '0) && (estado == OCIOSO);
  assign escreve = bypass && !Limpar;
  assign Ocupado = (estado == LIMPANDO);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      estado <= OCIOSO;
      indice <= IDX_PRIMEIRO;
    end else begin
      estado <= prox_estado;
      indice <= prox_indice;
    end
  end

  always_comb begin
    prox_estado = estado;
    prox_indice = indice;
    case (estado)
      OCIOSO: begin
        if (Limpar) begin
          prox_estado = LIMPANDO;
          prox_indice = IDX_PRIMEIRO;
        end
      end
      LIMPANDO: begin
        if (indice == IDX_ULTIMO) begin
          prox_estado = OCIOSO;
          prox_indice = IDX_PRIMEIRO;
        end else begin
          prox_indice = indice + IDX_PRIMEIRO;
        end
      end
      default: begin
        prox_estado = OCIOSO;
        prox_indice = IDX_PRIMEIRO;
      end
    endcase
  end

  // Index never reaches 0 and escreve excludes address 0, so regs[0] stays zero.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (estado == LIMPANDO) begin
      regs[indice] <= '0;
    end else if (escreve) begin
      regs[EndEscrita] <= DadoEscrita;
    end
  end

  always_comb begin
    Leitura0 = '0;
    if (Reset) begin
      if (bypass && (EndEscrita == EndLeitura0)) begin
        Leitura0 = DadoEscrita;
      end else if (EndLeitura0 != '0) begin
        Leitura0 = regs[EndLeitura0];
      end
    end
  end

  always_comb begin
    Leitura1 = '0;
    if (Reset) begin
      if (bypass && (EndEscrita == EndLeitura1)) begin
        Leitura1 = DadoEscrita;
      end else if (EndLeitura1 != '0) begin
        Leitura1 = regs[EndLeitura1];
      end
    end
  end

endmodule
